// File: rtl/memory_arbiter.sv
// Two-port (L1I/L1D) memory front end: round-robin valid/ready arbitration, ROM/RAM/peripheral
// decode, MEM_LATENCY-cycle backing-store access and a one-cycle response pulse per request.
module memory_arbiter #(
    parameter int ROM_SIZE    = 32,
    parameter int RAM_SIZE    = 32,
    parameter int MEM_LATENCY = 2,
    parameter int PERIPH_BIT  = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        l1i_req_valid,
    input  logic [31:0] l1i_address,
    output logic        l1i_req_ready,
    output logic        l1i_resp_valid,
    output logic [31:0] l1i_resp_data,
    output logic        l1i_resp_error,
    input  logic        l1d_req_valid,
    input  logic        l1d_req_write,
    input  logic [31:0] l1d_address,
    input  logic [31:0] l1d_wdata,
    output logic        l1d_req_ready,
    output logic        l1d_resp_valid,
    output logic [31:0] l1d_resp_data,
    output logic        l1d_resp_error,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_rdata,
    output logic [31:0] ram_address,
    output logic [31:0] ram_wdata,
    output logic        ram_write,
    input  logic [31:0] ram_rdata,
    output logic [31:0] per_address,
    output logic [31:0] per_wdata,
    output logic        per_write,
    input  logic [31:0] per_rdata
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_PER} region_t;

    state_t        state, state_nxt;
    region_t       region, dec_region;
    logic          last_grant, src, req_write;
    logic [CW-1:0] cnt;
    logic          grant_i, grant_d, sel_write, dec_err;
    logic [31:0]   sel_addr, word_idx, cap_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{l1i_address[1:0], l1d_address[1:0]};

    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_nxt  = state;
        if (state == IDLE) begin
            // Contention goes to whichever port did not win last time.
            grant_d = l1d_req_valid && (!l1i_req_valid || (last_grant == GRANT_I));
            grant_i = l1i_req_valid && !grant_d;
        end
        sel_addr   = grant_d ? l1d_address : l1i_address;
        sel_write  = grant_d && l1d_req_write;
        word_idx   = {2'b00, sel_addr[31:2]};
        dec_region = REG_ROM;
        dec_err    = 1'b0;
        if (sel_addr[PERIPH_BIT])
            dec_region = REG_PER;
        else if (word_idx < 32'(ROM_SIZE))
            dec_region = REG_ROM;
        else if (word_idx < 32'(ROM_SIZE + RAM_SIZE))
            dec_region = REG_RAM;
        else
            dec_err = 1'b1;
        if (sel_write && dec_region == REG_ROM)
            dec_err = 1'b1;
        case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = dec_err ? RESP : BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_data = '0;
        if (!req_write) begin
            case (region)
                REG_ROM: cap_data = rom_rdata;
                REG_RAM: cap_data = ram_rdata;
                REG_PER: cap_data = per_rdata;
                default: cap_data = '0;
            endcase
        end
    end

    assign l1i_req_ready  = grant_i;
    assign l1d_req_ready  = grant_d;
    assign l1i_resp_valid = (state == RESP) && (src == GRANT_I);
    assign l1d_resp_valid = (state == RESP) && (src == GRANT_D);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= GRANT_I;
            src            <= GRANT_I;
            req_write      <= 1'b0;
            region         <= REG_ROM;
            cnt            <= '0;
            rom_address    <= '0;
            ram_address    <= '0;
            ram_wdata      <= '0;
            ram_write      <= 1'b0;
            per_address    <= '0;
            per_wdata      <= '0;
            per_write      <= 1'b0;
            l1i_resp_data  <= '0;
            l1i_resp_error <= 1'b0;
            l1d_resp_data  <= '0;
            l1d_resp_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            ram_write <= 1'b0;
            per_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        last_grant <= grant_d;
                        src        <= grant_d;
                        req_write  <= sel_write;
                        region     <= dec_region;
                        cnt        <= CW'(MEM_LATENCY - 1);
                        if (dec_err) begin
                            // Decode failures answer immediately without touching any store.
                            if (grant_d) begin
                                l1d_resp_data  <= '0;
                                l1d_resp_error <= 1'b1;
                            end else begin
                                l1i_resp_data  <= '0;
                                l1i_resp_error <= 1'b1;
                            end
                        end else begin
                            case (dec_region)
                                REG_ROM: rom_address <= word_idx;
                                REG_RAM: begin
                                    ram_address <= word_idx - 32'(ROM_SIZE);
                                    ram_write   <= sel_write;
                                    if (sel_write) ram_wdata <= l1d_wdata;
                                end
                                REG_PER: begin
                                    per_address <= 32'(sel_addr[PERIPH_BIT-1:2]);
                                    per_write   <= sel_write;
                                    if (sel_write) per_wdata <= l1d_wdata;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (src == GRANT_D) begin
                            l1d_resp_data  <= cap_data;
                            l1d_resp_error <= 1'b0;
                        end else begin
                            l1i_resp_data  <= cap_data;
                            l1i_resp_error <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Parametrised successor to the single-cycle instruction/data memory front end. It arbitrates between the L1I and L1D requestors using valid/ready handshakes, decodes each request into a ROM, RAM or peripheral region, and drives the backing stores for MEM_LATENCY cycles. It then returns a one-cycle response pulse carrying data and an error flag. Sits between the L1 caches and the rom/ram/peripherals instances; it replaces fixed stall wiring with explicit handshakes.

Parameters:
ROM_SIZE, 32, ROM depth in 32-bit words; occupies word indices [0, ROM_SIZE).
RAM_SIZE, 32, RAM depth in words; occupies word indices [ROM_SIZE, ROM_SIZE+RAM_SIZE).
MEM_LATENCY, 2, backing-store access cycles; legal values >= 1.
PERIPH_BIT, 31, address bit that selects the peripheral region.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
l1i_req_valid  in  1  instruction fetch request
l1i_address  in  32  byte address; bits [1:0] ignored
l1i_req_ready  out  1  request accepted this cycle
l1i_resp_valid  out  1  one-cycle response pulse
l1i_resp_data  out  32  read data
l1i_resp_error  out  1  decode error
l1d_req_valid  in  1  data request
l1d_req_write  in  1  1 = write, 0 = read
l1d_address  in  32  byte address; bits [1:0] ignored
l1d_wdata  in  32  write data
l1d_req_ready  out  1  request accepted
l1d_resp_valid  out  1  one-cycle response pulse
l1d_resp_data  out  32  read data (0 on write or error)
l1d_resp_error  out  1  decode error
rom_address  out  32  ROM word index
rom_rdata  in  32  ROM read data
ram_address  out  32  RAM word offset (word index - ROM_SIZE)
ram_wdata  out  32  RAM write data
ram_write  out  1  RAM write strobe
ram_rdata  in  32  RAM read data
per_address  out  32  peripheral word index (address[PERIPH_BIT-1:2])
per_wdata  out  32  peripheral write data
per_write  out  1  peripheral write strobe
per_rdata  in  32  peripheral read data

Behaviour:
- Reset: state IDLE; last_grant = I; all resp_valid, resp_data, resp_error, ram_write and per_write = 0; all backing addresses and wdata = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE, arbitration:
  - A single valid requestor is granted.
  - If both are valid, the port not in last_grant is granted; after reset D therefore wins first.
  - req_ready is combinational and high only for the granted port, only in IDLE. Handshake cycle = T.
  - At T the block latches address, write flag, wdata and source, and updates last_grant.
- Decode, in priority order:
  1. address[PERIPH_BIT] = 1: peripheral region.
  2. word index < ROM_SIZE: ROM.
  3. word index < ROM_SIZE+RAM_SIZE: RAM.
  4. Otherwise: error.
  - Writes to ROM and L1I writes are errors; L1I is always a read.
- Error path: IDLE -> RESP directly; resp_error = 1, resp_data = 0; resp_valid at T+1; no backing access, no write strobe.
- Valid path: IDLE -> BUSY with counter = MEM_LATENCY-1.
  - Backing address and wdata are held stable for the whole of BUSY.
  - The write strobe (ram_write or per_write) is high only in the first BUSY cycle.
  - When the counter reaches 0, the selected rdata is captured (reads only) and the FSM moves to RESP.
- RESP: resp_valid is high for exactly one cycle on the source port only, then IDLE. Read response at T+MEM_LATENCY+1. No new grant is issued in RESP.
- Throughput: one request per MEM_LATENCY+2 cycles.
- A requestor must hold valid and its inputs until ready; after a grant it may drop or change them freely.
- Reset in any state: next cycle is IDLE with no response issued. A write strobe already issued is not undone.
- resp_data and resp_error hold their value outside the pulse until the next response.

Test Plan:
- Reset, then l1i read 0x0000_0008 at T -> rom_address = 2; l1i_resp_valid only at T+3 with data = rom_rdata, error = 0; l1d_resp_valid stays 0.
- l1d write 0x0000_0084, wdata 0xDEADBEEF -> ram_address = 1, ram_wdata = 0xDEADBEEF, ram_write high exactly at T+1; l1d_resp_valid at T+3, error = 0.
- Both valid continuously after reset -> D granted at T and I granted at T+4. Then a second simultaneous pair, requests issued at T+8 -> D granted again. Verify no simultaneous ready assertions.
- l1d write 0x0000_0010 (ROM) -> resp at T+1 with error = 1 and no strobes. l1i read 0x0000_0100 (word 64) -> error = 1, data = 0.
- l1d write 0x8000_0004 -> per_address = 1, per_write pulses once, ram_write stays 0. Then a read of 0x8000_0004 returns per_rdata.
- Assert reset during BUSY of a RAM read -> no resp_valid ever appears; the next l1i request completes with normal latency.
